// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage
// and a DMA/debug-loader port. Round-robin arbitration with an optional DMA
// burst lock of at most MAX_BURST consecutive grants, after which the core is
// guaranteed one RELEASE cycle.
// Optional feature macro: DMEM_ARB_PERF_EN enables the stall/DMA-grant
// performance counters; without it both counter outputs are tied to zero.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic [DW-1:0] c_rdata,
  output logic          stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_dma_cnt
);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } st_t;

  // Last burst count value at which a further locked grant ends the burst.
  localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);

  st_t        st;
  logic       prio;
  logic [3:0] bcnt;

  // Grant decision: combinational from current requests and registered state.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    case (st)
      BURST: begin
        if (d_req && d_lock) begin
          d_gnt = 1'b1;
        end else if (c_req) begin
          c_gnt = 1'b1;
        end else begin
          d_gnt = d_req;
        end
      end
      RELEASE: begin
        c_gnt = c_req;
      end
      default: begin
        if (c_req && d_req) begin
          c_gnt = ~prio;
          d_gnt = prio;
        end else begin
          c_gnt = c_req;
          d_gnt = d_req;
        end
      end
    endcase
  end

  // Memory port follows the granted side; the core side is the idle default.
  always_comb begin
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
    end else begin
      m_addr  = c_addr;
      m_wdata = c_wdata;
      m_we    = c_gnt & c_we;
    end
  end

  assign stall   = c_req & ~c_gnt;
  assign c_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Arbitration FSM: round-robin priority plus bounded DMA burst ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= ARB;
      prio <= 1'b0;
      bcnt <= 4'd0;
    end else begin
      case (st)
        ARB: begin
          if (c_req && d_req) begin
            prio <= c_gnt;
          end
          if (d_gnt && d_lock) begin
            if (MAX_BURST == 1) begin
              st <= RELEASE;
            end else begin
              bcnt <= 4'd1;
              st   <= BURST;
            end
          end
        end
        BURST: begin
          if (d_req && d_lock) begin
            if (bcnt < BCNT_LAST) begin
              bcnt <= bcnt + 4'd1;
            end else begin
              st <= RELEASE;
            end
          end else begin
            st   <= ARB;
            prio <= 1'b0;
            bcnt <= 4'd0;
          end
        end
        RELEASE: begin
          st   <= ARB;
          prio <= 1'b0;
          bcnt <= 4'd0;
        end
        default: begin
          st   <= ARB;
          prio <= 1'b0;
          bcnt <= 4'd0;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Free-running wrap-around counters of core stall cycles and DMA grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_dma_cnt   <= 32'd0;
    end else begin
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (d_gnt) begin
        perf_dma_cnt <= perf_dma_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_dma_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_gnt, stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] perf_stall_cnt, perf_dma_cnt;

`ifdef DMEM_ARB_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  typedef struct {
    string       name;
    logic        c_gnt;
    logic        d_gnt;
    logic        stall;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] rdata;
    bit          chk_perf;
    logic [31:0] p_stall;
    logic [31:0] p_dma;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_idx = 0;
  bit          perf_armed = 1'b0;
  logic [31:0] perf_s_exp, perf_d_exp;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .stall(stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
  );

  always #5 clk = ~clk;

  // Single field comparison; every comparison goes through here.
  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
    end
  endtask

  // Request a perf-counter check on the next issued vector.
  task automatic armPerf(input logic [31:0] s, input logic [31:0] d);
    perf_armed = 1'b1;
    perf_s_exp = s;
    perf_d_exp = d;
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the expectation.
  task automatic applyStimulus(input string name, input bit rst_v,
                               input bit cr, input bit cw,
                               input logic [31:0] ca, input logic [31:0] cd,
                               input bit dr, input bit dw, input bit dl,
                               input logic [31:0] da, input logic [31:0] dd,
                               input bit ec, input bit ed, input bit es, input bit ew,
                               input logic [31:0] ea, input logic [31:0] ewd);
    exp_t e;
    @(posedge clk);
    #1;
    vec_idx++;
    reset   = rst_v;
    c_req   = cr;  c_we = cw;  c_addr = ca;  c_wdata = cd;
    d_req   = dr;  d_we = dw;  d_lock = dl;  d_addr = da;  d_wdata = dd;
    m_rdata = 32'hD000_0000 | 32'(vec_idx);
    e.name     = name;
    e.c_gnt    = ec;
    e.d_gnt    = ed;
    e.stall    = es;
    e.m_we     = ew;
    e.m_addr   = ea;
    e.m_wdata  = ewd;
    e.rdata    = 32'hD000_0000 | 32'(vec_idx);
    e.chk_perf = perf_armed;
    e.p_stall  = perf_s_exp;
    e.p_dma    = perf_d_exp;
    perf_armed = 1'b0;
    exp_q.push_back(e);
  endtask

  // One cycle with all requests low and nothing queued.
  task automatic idleCycle(input bit rst_v);
    @(posedge clk);
    #1;
    reset = rst_v;
    c_req = 1'b0; c_we = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
  endtask

  // Monitor: compares the DUT outputs against the queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.name, "c_gnt", 32'(c_gnt), 32'(e.c_gnt));
      checkOutput(e.name, "d_gnt", 32'(d_gnt), 32'(e.d_gnt));
      checkOutput(e.name, "stall", 32'(stall), 32'(e.stall));
      checkOutput(e.name, "m_we", 32'(m_we), 32'(e.m_we));
      checkOutput(e.name, "m_addr", m_addr, e.m_addr);
      checkOutput(e.name, "m_wdata", m_wdata, e.m_wdata);
      checkOutput(e.name, "c_rdata", c_rdata, e.rdata);
      checkOutput(e.name, "d_rdata", d_rdata, e.rdata);
      if (e.chk_perf) begin
        checkOutput(e.name, "perf_stall_cnt", perf_stall_cnt, e.p_stall);
        checkOutput(e.name, "perf_dma_cnt", perf_dma_cnt, e.p_dma);
      end
    end
  end

  localparam logic [31:0] CA = 32'h200, CD = 32'h11, DA = 32'h300, DD = 32'h22;

  initial begin
    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    m_rdata = 32'h0;
    perf_s_exp = 32'h0;
    perf_d_exp = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: no grants, memory mux shows the core side.
    armPerf(32'd0, 32'd0);
    applyStimulus("reset_idle", 0, 0,0, 32'h44,32'h55, 0,0,0, DA,DD, 0,0,0,0, 32'h44,32'h55);

    // Core-only write.
    applyStimulus("core_only", 0, 1,1, 32'd100,32'd25, 0,0,0, DA,DD, 1,0,0,1, 32'd100,32'd25);

    // Contention without lock: core, DMA, core, DMA.
    applyStimulus("cont0", 0, 1,0, CA,CD, 1,1,0, DA,DD, 1,0,0,0, CA,CD);
    applyStimulus("cont1", 0, 1,0, CA,CD, 1,1,0, DA,DD, 0,1,1,1, DA,DD);
    applyStimulus("cont2", 0, 1,0, CA,CD, 1,1,0, DA,DD, 1,0,0,0, CA,CD);
    applyStimulus("cont3", 0, 1,0, CA,CD, 1,1,0, DA,DD, 0,1,1,1, DA,DD);
    armPerf(PERF_ON != 0 ? 32'd2 : 32'd0, PERF_ON != 0 ? 32'd2 : 32'd0);
    applyStimulus("perf_after_cont", 0, 0,0, CA,CD, 0,0,0, DA,DD, 0,0,0,0, CA,CD);

    // Locked burst: core wins first contention, then 4 DMA grants, then RELEASE.
    applyStimulus("burst_arb_core", 0, 1,1, CA,CD, 1,1,1, DA,DD, 1,0,0,1, CA,CD);
    applyStimulus("burst_d0", 0, 1,1, CA,CD, 1,1,1, DA,DD, 0,1,1,1, DA,DD);
    applyStimulus("burst_d1", 0, 1,1, CA,CD, 1,1,1, DA,DD, 0,1,1,1, DA,DD);
    applyStimulus("burst_d2", 0, 1,1, CA,CD, 1,1,1, DA,DD, 0,1,1,1, DA,DD);
    applyStimulus("burst_d3", 0, 1,1, CA,CD, 1,1,1, DA,DD, 0,1,1,1, DA,DD);
    applyStimulus("burst_release", 0, 1,1, CA,CD, 1,1,1, DA,DD, 1,0,0,1, CA,CD);
    idleCycle(0);

    // Burst exit after two locked grants, then core wins the next contention.
    applyStimulus("exit_d0", 0, 0,0, CA,CD, 1,0,1, DA,DD, 0,1,0,0, DA,DD);
    applyStimulus("exit_d1", 0, 1,0, CA,CD, 1,0,1, DA,DD, 0,1,1,0, DA,DD);
    applyStimulus("exit_unlock", 0, 0,0, CA,CD, 1,1,0, DA,DD, 0,1,0,1, DA,DD);
    applyStimulus("exit_core_first", 0, 1,0, CA,CD, 1,1,0, DA,DD, 1,0,0,0, CA,CD);

    // Reach BURST with bcnt=2, then reset asynchronously mid-cycle.
    applyStimulus("rb_d0", 0, 0,0, CA,CD, 1,1,1, DA,DD, 0,1,0,1, DA,DD);
    applyStimulus("rb_d1", 0, 0,0, CA,CD, 1,1,1, DA,DD, 0,1,0,1, DA,DD);
    armPerf(32'd0, 32'd0);
    applyStimulus("rb_reset", 1, 1,0, CA,CD, 1,1,1, DA,DD, 1,0,0,0, CA,CD);
    idleCycle(1);
    idleCycle(0);
    applyStimulus("post_reset_core", 0, 1,0, CA,CD, 1,1,0, DA,DD, 1,0,0,0, CA,CD);
    applyStimulus("post_reset_dma", 0, 1,0, CA,CD, 1,1,0, DA,DD, 0,1,1,1, DA,DD);

    idleCycle(0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
